// File: rtl/scroll_pkg.sv
// scroll_pkg: shared default constants for the scroll offset path.
//   DEBOUNCE_CYCLES - clk cycles a new synced button level must persist
//   STEP            - offset increment per accepted press
//   H_ACTIVE        - offset modulus (offset stays in 0..H_ACTIVE-1)
//   OFFSET_W        - offset width
//   PEND_W          - pending-step counter width
//   REPEAT_FRAMES   - frames between auto-repeat steps (SCROLL_REPEAT_EN only)
//   PEND_MAX        - saturation value of the pending counter
package scroll_pkg;

    localparam int DEBOUNCE_CYCLES = 250000;
    localparam int STEP            = 10;
    localparam int H_ACTIVE        = 640;
    localparam int OFFSET_W        = 10;
    localparam int PEND_W          = 3;
    localparam int REPEAT_FRAMES   = 30;

    // Largest value an unsigned counter of width w can hold.
    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int PEND_MAX = sat_max(PEND_W);

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer followed by a hold-time debouncer.
// A new synced level is accepted only after it has persisted for
// DEBOUNCE_CYCLES consecutive clocks; any return to the accepted level
// restarts the count.
// Ports:
//   clk_i        - clock
//   rst_ni       - asynchronous active-low reset
//   button_i     - raw asynchronous button, active-high
//   btn_stable_o - debounced level (registered)
//   press_o      - one-cycle pulse in the first cycle btn_stable_o is 1
module btn_debounce
    import scroll_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = scroll_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic button_i,
    output logic btn_stable_o,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             b_s;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign b_s = sync_q[1];

    always_comb begin
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = cnt_q;
        if (b_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Level held long enough: accept it; only the rising side is an event.
            stable_d = b_s;
            press_d  = b_s;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], button_i};
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_stable_o = stable_q;
    assign press_o      = press_q;

endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: turns a raw push-button into a debounced, frame-aligned
// horizontal scroll offset for the vmem `i` input. Presses are queued and
// applied one per frame at the first clk of the vsync low pulse, so a frame
// never tears.
// Optional build macro: SCROLL_REPEAT_EN - while the button is held, one
// extra press-equivalent step is queued every REPEAT_FRAMES frames.
// Ports:
//   clk        - pixel clock (same as vga_ctrl)
//   rst        - asynchronous active-low reset, release synchronised to clk
//   button     - raw asynchronous push-button, active-high
//   vsync      - vga_ctrl vsync, active-low pulse, synchronous to clk
//   offset     - scroll offset, 0..H_ACTIVE-1
//   pending    - queued steps not yet applied (saturating)
//   btn_stable - debounced button level
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = scroll_pkg::DEBOUNCE_CYCLES,
    parameter int STEP            = scroll_pkg::STEP,
    parameter int H_ACTIVE        = scroll_pkg::H_ACTIVE,
    parameter int OFFSET_W        = scroll_pkg::OFFSET_W,
`ifdef SCROLL_REPEAT_EN
    parameter int REPEAT_FRAMES   = scroll_pkg::REPEAT_FRAMES,
`endif
    parameter int PEND_W          = scroll_pkg::PEND_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    input  logic                vsync,
    output logic [OFFSET_W-1:0] offset,
    output logic [PEND_W-1:0]   pending,
    output logic                btn_stable
);

    // Elaboration-time sanity checks.
    if (STEP >= H_ACTIVE) begin : g_bad_step
        $error("scroll_ctrl: STEP must be smaller than H_ACTIVE");
    end
    if (H_ACTIVE > (1 << OFFSET_W)) begin : g_bad_width
        $error("scroll_ctrl: H_ACTIVE does not fit in OFFSET_W bits");
    end

    localparam logic [OFFSET_W:0]   STEP_X   = (OFFSET_W + 1)'(STEP);
    localparam logic [OFFSET_W:0]   H_X      = (OFFSET_W + 1)'(H_ACTIVE);
    localparam logic [PEND_W-1:0]   PEND_TOP = PEND_W'(sat_max(PEND_W));

    // Reset asserts asynchronously, releases on a clk edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i       (clk),
        .rst_ni      (rst_n_int),
        .button_i    (button),
        .btn_stable_o(btn_stable),
        .press_o     (press)
    );

    logic                vsync_d_q;
    logic                tick;
    logic                inc;
    logic                dec;
    logic [OFFSET_W:0]   sum_w;
    logic [OFFSET_W-1:0] step_val;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [PEND_W-1:0]   pending_q, pending_d;

    // First clk of the vsync low pulse.
    assign tick = vsync_d_q & ~vsync;

`ifdef SCROLL_REPEAT_EN
    localparam int REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_fire;

    // Counts frames while held; restarts on the press edge so the
    // first repeat comes a full REPEAT_FRAMES after the press itself.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_fire  = 1'b0;
        if (!btn_stable || press) begin
            rep_cnt_d = '0;
        end else if (tick) begin
            if (rep_cnt_q == REP_LAST) begin
                rep_cnt_d = '0;
                rep_fire  = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign inc = press | rep_fire;
`else
    assign inc = press;
`endif

    assign dec = tick & (pending_q != '0);

    always_comb begin
        // Add at OFFSET_W+1 bits so the compare sees the true sum.
        sum_w = {1'b0, offset_q} + STEP_X;
        if (sum_w >= H_X) begin
            step_val = OFFSET_W'(sum_w - H_X);
        end else begin
            step_val = OFFSET_W'(sum_w);
        end

        offset_d = dec ? step_val : offset_q;

        // A press that coincides with an applied step leaves the count as is.
        pending_d = pending_q;
        if (inc && !dec) begin
            if (pending_q != PEND_TOP) begin
                pending_d = pending_q + 1'b1;
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            vsync_d_q <= 1'b1;
            offset_q  <= '0;
            pending_q <= '0;
        end else begin
            vsync_d_q <= vsync;
            offset_q  <= offset_d;
            pending_q <= pending_d;
        end
    end

    assign offset  = offset_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed bench for scroll_ctrl: two instances share stimulus, one with
// STEP=10 and one with STEP=15, both with an 8-cycle debounce.
module tb_scroll_ctrl;

  localparam int OW = 10;
  localparam int PW = 3;

`ifdef SCROLL_REPEAT_EN
  localparam int REP_STEPS = 4;
  localparam int REP_P3    = 1;
`else
  localparam int REP_STEPS = 1;
  localparam int REP_P3    = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic button = 1'b0;
  logic vsync = 1'b1;

  always #5 clk = ~clk;

  logic [OW-1:0] offset, offset15;
  logic [PW-1:0] pending, pending15;
  logic          btn_stable, btn_stable15;

  scroll_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .STEP(10),
    .H_ACTIVE(640),
    .OFFSET_W(OW),
`ifdef SCROLL_REPEAT_EN
    .REPEAT_FRAMES(3),
`endif
    .PEND_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .vsync(vsync),
    .offset(offset), .pending(pending), .btn_stable(btn_stable)
  );

  scroll_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .STEP(15),
    .H_ACTIVE(640),
    .OFFSET_W(OW),
`ifdef SCROLL_REPEAT_EN
    .REPEAT_FRAMES(3),
`endif
    .PEND_W(PW)
  ) dut15 (
    .clk(clk), .rst(rst), .button(button), .vsync(vsync),
    .offset(offset15), .pending(pending15), .btn_stable(btn_stable15)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press: stable after 10 edges, pending bumps one edge later.
  task automatic press_once();
    button = 1'b1;
    cyc(12);
    button = 1'b0;
    cyc(12);
  endtask

  // Two-cycle vsync low pulse; exactly one tick at its first clk.
  task automatic frame_tick();
    vsync = 1'b0;
    cyc(2);
    vsync = 1'b1;
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset held with inputs toggling.
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      button = i[0];
      vsync  = i[1];
      cyc(1);
      chk("rst_offset", offset, 0);
      chk("rst_pending", pending, 0);
      chk("rst_stable", btn_stable, 0);
    end
    button = 1'b0;
    vsync  = 1'b1;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("post_rst_offset", offset, 0);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_stable", btn_stable, 0);
    chk("post_rst_offset15", offset15, 0);
    cyc(5);

    // Bounce: short glitches must not be accepted.
    repeat (3) begin
      button = 1'b1;
      cyc(5);
      button = 1'b0;
      cyc(5);
    end
    cyc(3);
    chk("glitch_stable", btn_stable, 0);
    chk("glitch_pending", pending, 0);

    // Clean press: stable rises exactly 2+8 cycles after the edge.
    button = 1'b1;
    cyc(9);
    chk("edge_minus1_stable", btn_stable, 0);
    cyc(1);
    chk("edge_exact_stable", btn_stable, 1);
    cyc(1);
    chk("press_pending", pending, 1);
    chk("press_offset", offset, 0);
    cyc(9);
    button = 1'b0;
    cyc(12);
    chk("release_stable", btn_stable, 0);
    chk("release_pending", pending, 1);
    chk("release_offset", offset, 0);
    frame_tick();
    chk("first_step_offset", offset, 10);
    chk("first_step_pending", pending, 0);
    chk("first_step_offset15", offset15, 15);

    // Queue and saturation: 9 presses, only 7 kept.
    repeat (9) press_once();
    chk("sat_pending", pending, 7);
    chk("sat_pending15", pending15, 7);
    chk("sat_offset_hold", offset, 10);
    for (int k = 1; k <= 7; k++) exp_q.push_back(OW'(10 + 10 * k));
    for (int k = 1; k <= 7; k++) begin
      frame_tick();
      chk("queue_offset", offset, exp_q.pop_front());
      chk("queue_pending", pending, 7 - k);
      chk("queue_offset15", offset15, 15 + 15 * k);
    end
    frame_tick();
    chk("idle_tick_offset", offset, 80);
    chk("idle_tick_pending", pending, 0);

    // Walk toward wrap; STEP=15 instance wraps 630 -> 5 on the way.
    for (int s = 9; s <= 63; s++) begin
      press_once();
      frame_tick();
      chk("walk_offset", offset, (s * 10) % 640);
      chk("walk_offset15", offset15, (s * 15) % 640);
    end
    chk("pre_wrap_offset", offset, 630);
    chk("pre_wrap_offset15", offset15, 305);
    press_once();
    frame_tick();
    chk("wrap_offset", offset, 0);
    chk("wrap_offset15", offset15, 320);

    // Press pulse on the tick cycle with pending=2.
    press_once();
    press_once();
    chk("simul_pre_pending", pending, 2);
    button = 1'b1;
    cyc(10);
    vsync = 1'b0;
    cyc(1);
    chk("simul2_offset", offset, 10);
    chk("simul2_pending", pending, 2);
    chk("simul2_offset15", offset15, 335);
    vsync = 1'b1;
    cyc(11);
    button = 1'b0;
    cyc(12);
    frame_tick();
    frame_tick();
    chk("drain_offset", offset, 30);
    chk("drain_pending", pending, 0);
    chk("drain_offset15", offset15, 365);

    // Press pulse on the tick cycle with pending=0.
    button = 1'b1;
    cyc(10);
    vsync = 1'b0;
    cyc(1);
    chk("simul0_offset", offset, 30);
    chk("simul0_pending", pending, 1);
    vsync = 1'b1;
    cyc(11);
    button = 1'b0;
    cyc(12);
    frame_tick();
    chk("simul0_applied_offset", offset, 40);
    chk("simul0_applied_pending", pending, 0);
    chk("simul0_applied_offset15", offset15, 380);

    // Hold the button across 10 frames.
    button = 1'b1;
    cyc(12);
    chk("hold_pending", pending, 1);
    for (int f = 1; f <= 10; f++) begin
      frame_tick();
      if (f == 3) chk("hold_pending_f3", pending, REP_P3);
    end
    chk("hold_offset", offset, 40 + 10 * REP_STEPS);
    chk("hold_offset15", offset15, 380 + 15 * REP_STEPS);
    chk("hold_pending_end", pending, 0);
    button = 1'b0;
    cyc(12);

    // Reset mid-debounce with a step pending discards everything.
    press_once();
    chk("mid_pre_pending", pending, 1);
    button = 1'b1;
    cyc(5);
    rst = 1'b0;
    #1;
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_offset", offset, 0);
    chk("mid_rst_stable", btn_stable, 0);
    cyc(2);
    button = 1'b0;
    rst = 1'b1;
    cyc(20);
    chk("mid_after_pending", pending, 0);
    chk("mid_after_offset15", offset15, 0);
    chk("mid_after_stable", btn_stable15, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
